// File: rtl/evr_dbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : evr_dbuf_pkg
// Description : Shared constants for the EVR data-buffer framer. Holds the
//               default K-character codes for frame delimiting, the payload
//               limit default, the pipeline latency and the framer state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package evr_dbuf_pkg;

    // K28.0 opens a data-buffer frame, K28.1 closes its payload.
    localparam logic [7:0] c_DEFAULT_START_CHAR  = 8'h1C;
    localparam logic [7:0] c_DEFAULT_STOP_CHAR   = 8'h3C;

    // Largest accepted payload; keeps the downstream write address < 2048.
    localparam int         c_DEFAULT_MAX_PAYLOAD = 2046;

    // Input-to-DataOut latency of the byte delay line.
    localparam int         c_LATENCY             = 2;

    // Number of cycles spent in ABORT_FILL before frames are accepted again.
    // Covers the abort pulse and both forced-zero output cycles.
    localparam int         c_FILL_CYCLES         = 5;

    // Framer state encoding.
    localparam int                   c_STATE_W     = 3;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE       = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_PAYLOAD    = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_CKSUM_HI   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_CKSUM_LO   = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_ABORT_FILL = 3'd4;

endpackage
`default_nettype wire

// File: rtl/evr_dbuf_framer.sv
`default_nettype none
// ============================================================================
// Module      : evr_dbuf_framer
// Description : Finds data-buffer frames (K28.0, payload, K28.1, 2 checksum
//               bytes) on the data lane of the decoded GTX byte stream and
//               re-times them for the EVR data-buffer controller. Malformed
//               or oversized frames are aborted and counted.
//
// Ports       : RxClock     in   recovered receive clock (only clock)
//               Reset       in   synchronous active-high reset
//               RxData      in   [7:0] decoded receive byte
//               RxCharIsK   in   RxData is a K character
//               RxDataLane  in   1 = this cycle carries the data-lane byte
//               PacketStart out  one-cycle start-of-frame pulse
//               PacketStop  out  one-cycle end-of-frame pulse
//               DataOut     out  [7:0] byte stream to the buffer controller
//               FrameError  out  one-cycle pulse when a frame is aborted
//               FrameCount  out  [15:0] frames closed normally (wraps)
//               ErrorCount  out  [15:0] frames aborted (saturates)
//
// Revision    : 1.0 - initial release
// ============================================================================
module evr_dbuf_framer
    import evr_dbuf_pkg::*;
#(
    parameter logic [7:0] START_CHAR  = c_DEFAULT_START_CHAR,
    parameter logic [7:0] STOP_CHAR   = c_DEFAULT_STOP_CHAR,
    parameter int         MAX_PAYLOAD = c_DEFAULT_MAX_PAYLOAD
) (
    input  logic        RxClock,
    input  logic        Reset,
    input  logic [7:0]  RxData,
    input  logic        RxCharIsK,
    input  logic        RxDataLane,
    output logic        PacketStart,
    output logic        PacketStop,
    output logic [7:0]  DataOut,
    output logic        FrameError,
    output logic [15:0] FrameCount,
    output logic [15:0] ErrorCount
);

    // Frame events are detected on the input byte and emitted one cycle
    // after that byte would leave the delay line, hence LATENCY+1 stages.
    localparam int                 c_PIPE_LEN  = c_LATENCY + 1;
    localparam int                 c_CNT_W     = $clog2(MAX_PAYLOAD + 2);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT   = c_CNT_W'(MAX_PAYLOAD);
    localparam logic [2:0]         c_FILL_LAST = 3'(c_FILL_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_nextState;
    logic [c_CNT_W-1:0]    r_payloadCnt;
    logic [2:0]            r_fillCnt;
    logic                  r_prevLane;
    logic [7:0]            r_dly1;
    logic [7:0]            r_dataOut;
    logic [c_PIPE_LEN-1:0] r_startPipe;
    logic [c_PIPE_LEN-1:0] r_stopPipe;
    // One stage longer than the others so the second forced-zero cycle
    // can be keyed off the abort pipe as well.
    logic [c_PIPE_LEN:0]   r_abortPipe;
    logic [15:0]           r_frameCount;
    logic [15:0]           r_errorCount;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic w_laneSlip;
    logic w_forceZero;
    logic w_startEvt;
    logic w_stopEvt;
    logic w_abortEvt;
    logic w_lsbEvt;
    logic w_payloadByte;

    // The lane flag must toggle every cycle; a repeat means we lost sync.
    assign w_laneSlip  = (RxDataLane == r_prevLane);

    // Zero the two output cycles that follow the abort pulse so the
    // downstream checksum cannot match.
    assign w_forceZero = r_abortPipe[c_PIPE_LEN-1] | r_abortPipe[c_PIPE_LEN];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge RxClock) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and frame events
    // ------------------------------------------------------------------------
    always_comb begin
        w_nextState   = r_state;
        w_startEvt    = 1'b0;
        w_stopEvt     = 1'b0;
        w_abortEvt    = 1'b0;
        w_lsbEvt      = 1'b0;
        w_payloadByte = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (RxDataLane && RxCharIsK && (RxData == START_CHAR)) begin
                    w_startEvt  = 1'b1;
                    w_nextState = c_ST_PAYLOAD;
                end
            end

            c_ST_PAYLOAD: begin
                if (w_laneSlip) begin
                    w_abortEvt = 1'b1;
                end else if (RxDataLane) begin
                    if (RxCharIsK) begin
                        // STOP_CHAR closes the payload; any other K code,
                        // including a second START_CHAR, is malformed.
                        if (RxData == STOP_CHAR) begin
                            w_stopEvt   = 1'b1;
                            w_nextState = c_ST_CKSUM_HI;
                        end else begin
                            w_abortEvt = 1'b1;
                        end
                    end else if (r_payloadCnt == c_MAX_CNT) begin
                        w_abortEvt = 1'b1;
                    end else begin
                        w_payloadByte = 1'b1;
                    end
                end
            end

            c_ST_CKSUM_HI: begin
                if (w_laneSlip) begin
                    w_abortEvt = 1'b1;
                end else if (RxDataLane) begin
                    if (RxCharIsK) begin
                        w_abortEvt = 1'b1;
                    end else begin
                        w_nextState = c_ST_CKSUM_LO;
                    end
                end
            end

            c_ST_CKSUM_LO: begin
                if (w_laneSlip) begin
                    w_abortEvt = 1'b1;
                end else if (RxDataLane) begin
                    if (RxCharIsK) begin
                        w_abortEvt = 1'b1;
                    end else begin
                        w_lsbEvt    = 1'b1;
                        w_nextState = c_ST_IDLE;
                    end
                end
            end

            c_ST_ABORT_FILL: begin
                // Start characters seen here are deliberately ignored.
                if (r_fillCnt == c_FILL_LAST) begin
                    w_nextState = c_ST_IDLE;
                end
            end

            default: begin
                w_nextState = c_ST_IDLE;
            end
        endcase

        if (w_abortEvt) begin
            w_nextState = c_ST_ABORT_FILL;
        end
    end

    // ------------------------------------------------------------------------
    // Delay line, event pipes and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge RxClock) begin
        if (Reset) begin
            r_prevLane   <= 1'b0;
            r_dly1       <= 8'h00;
            r_dataOut    <= 8'h00;
            r_startPipe  <= '0;
            r_stopPipe   <= '0;
            r_abortPipe  <= '0;
            r_payloadCnt <= '0;
            r_fillCnt    <= 3'd0;
            r_frameCount <= 16'h0000;
            r_errorCount <= 16'h0000;
        end else begin
            r_prevLane <= RxDataLane;
            r_dly1     <= RxData;

            // The checksum LSB skips the first delay stage so that it lands
            // right after the MSB, on what would be an event-lane slot.
            if (w_forceZero) begin
                r_dataOut <= 8'h00;
            end else if (w_lsbEvt) begin
                r_dataOut <= RxData;
            end else begin
                r_dataOut <= r_dly1;
            end

            r_startPipe <= {r_startPipe[c_PIPE_LEN-2:0], w_startEvt};
            r_stopPipe  <= {r_stopPipe[c_PIPE_LEN-2:0], (w_stopEvt | w_abortEvt)};
            r_abortPipe <= {r_abortPipe[c_PIPE_LEN-1:0], w_abortEvt};

            if (w_startEvt) begin
                r_payloadCnt <= '0;
            end else if (w_payloadByte) begin
                r_payloadCnt <= r_payloadCnt + 1'b1;
            end

            if (w_abortEvt) begin
                r_fillCnt <= 3'd0;
            end else if (r_state == c_ST_ABORT_FILL) begin
                r_fillCnt <= r_fillCnt + 3'd1;
            end

            if (w_lsbEvt) begin
                r_frameCount <= r_frameCount + 16'd1;
            end

            // Counted on the cycle before FrameError so both become visible
            // together.
            if (r_abortPipe[c_PIPE_LEN-2] && (r_errorCount != 16'hFFFF)) begin
                r_errorCount <= r_errorCount + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign PacketStart = r_startPipe[c_PIPE_LEN-1];
    assign PacketStop  = r_stopPipe[c_PIPE_LEN-1];
    assign FrameError  = r_abortPipe[c_PIPE_LEN-1];
    assign DataOut     = r_dataOut;
    assign FrameCount  = r_frameCount;
    assign ErrorCount  = r_errorCount;

endmodule
`default_nettype wire
